// File: rtl/operand_fetch_seq.sv
// Two-operand fetch sequencer around a 4-input operand mux. It drives the mux
// select and captures the mux output into registers A and B on consecutive cycles.
module operand_fetch_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int SELECT_SIZE = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   start_i,
  input  logic                   single_i,
  input  logic [SELECT_SIZE-1:0] src_a_i,
  input  logic [SELECT_SIZE-1:0] src_b_i,
  input  logic [DATA_WIDTH-1:0]  mux_data_i,
  output logic [SELECT_SIZE-1:0] select_o,
  output logic [DATA_WIDTH-1:0]  operand_a_o,
  output logic [DATA_WIDTH-1:0]  operand_b_o,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [1:0] {IDLE, FETCH_A, FETCH_B, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SELECT_SIZE-1:0] select_q, select_d;
  logic [SELECT_SIZE-1:0] src_b_q, src_b_d;
  logic                   single_q, single_d;
  logic [DATA_WIDTH-1:0]  operand_a_q, operand_a_d;
  logic [DATA_WIDTH-1:0]  operand_b_q, operand_b_d;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      select_q    <= '0;
      src_b_q     <= '0;
      single_q    <= 1'b0;
      operand_a_q <= '0;
      operand_b_q <= '0;
    end else begin
      state_q     <= state_d;
      select_q    <= select_d;
      src_b_q     <= src_b_d;
      single_q    <= single_d;
      operand_a_q <= operand_a_d;
      operand_b_q <= operand_b_d;
    end
  end

  // The select is switched one edge ahead of each capture so the mux output
  // is settled for the full cycle before it is sampled.
  always_comb begin
    state_d     = state_q;
    select_d    = select_q;
    src_b_d     = src_b_q;
    single_d    = single_q;
    operand_a_d = operand_a_q;
    operand_b_d = operand_b_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          select_d = src_a_i;
          src_b_d  = src_b_i;
          single_d = single_i;
          state_d  = FETCH_A;
        end
      end
      FETCH_A: begin
        operand_a_d = mux_data_i;
        if (single_q) begin
          state_d = DONE;
        end else begin
          select_d = src_b_q;
          state_d  = FETCH_B;
        end
      end
      FETCH_B: begin
        operand_b_d = mux_data_i;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign select_o    = select_q;
  assign operand_a_o = operand_a_q;
  assign operand_b_o = operand_b_q;
  assign busy_o      = (state_q == FETCH_A) || (state_q == FETCH_B);
  assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Self-checking bench for operand_fetch_seq: table-driven fetches, hand-written
// corner sequences, then random stimulus against a transaction-age reference model.
module tb_operand_fetch_seq;

  logic        clk_i;
  logic        reset_ni;
  logic        start_i;
  logic        single_i;
  logic [1:0]  src_a_i;
  logic [1:0]  src_b_i;
  logic [15:0] mux_data_i;
  logic [1:0]  select_o;
  logic [15:0] operand_a_o;
  logic [15:0] operand_b_o;
  logic        busy_o;
  logic        done_o;

  logic [15:0] mux_in [4];
  int          n_checks;
  int          n_fail;

  operand_fetch_seq #(.DATA_WIDTH(16), .SELECT_SIZE(2)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .start_i     (start_i),
    .single_i    (single_i),
    .src_a_i     (src_a_i),
    .src_b_i     (src_b_i),
    .mux_data_i  (mux_data_i),
    .select_o    (select_o),
    .operand_a_o (operand_a_o),
    .operand_b_o (operand_b_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  // Behavioural Mux4 sitting on the select output.
  assign mux_data_i = mux_in[select_o];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic        single;
    logic [1:0]  src_a;
    logic [1:0]  src_b;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [5];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic set_default_mux();
    mux_in[0] = 16'h000A;
    mux_in[1] = 16'h00A0;
    mux_in[2] = 16'h0A00;
    mux_in[3] = 16'hA000;
  endtask

  // Drives one start from IDLE and checks every cycle up to the return to IDLE.
  task automatic apply_stimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk_i);
    start_i  = 1'b1;
    single_i = v.single;
    src_a_i  = v.src_a;
    src_b_i  = v.src_b;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i  = 1'b0;
    src_a_i  = ~v.src_a;
    src_b_i  = ~v.src_b;
    single_i = ~v.single;
    check_output({tag, " E0 select"}, 32'(select_o), 32'(v.src_a));
    check_output({tag, " E0 busy"}, 32'(busy_o), 32'd1);
    check_output({tag, " E0 done"}, 32'(done_o), 32'd0);
    @(negedge clk_i);
    check_output({tag, " E1 operand_a"}, 32'(operand_a_o), 32'(v.exp_a));
    if (v.single) begin
      check_output({tag, " E1 done"}, 32'(done_o), 32'd1);
      check_output({tag, " E1 busy"}, 32'(busy_o), 32'd0);
      check_output({tag, " E1 operand_b"}, 32'(operand_b_o), 32'(v.exp_b));
    end else begin
      check_output({tag, " E1 select"}, 32'(select_o), 32'(v.src_b));
      check_output({tag, " E1 busy"}, 32'(busy_o), 32'd1);
      check_output({tag, " E1 done"}, 32'(done_o), 32'd0);
      @(negedge clk_i);
      check_output({tag, " E2 operand_b"}, 32'(operand_b_o), 32'(v.exp_b));
      check_output({tag, " E2 done"}, 32'(done_o), 32'd1);
      check_output({tag, " E2 busy"}, 32'(busy_o), 32'd0);
    end
    @(negedge clk_i);
    check_output({tag, " after done"}, 32'(done_o), 32'd0);
    check_output({tag, " after busy"}, 32'(busy_o), 32'd0);
  endtask

  // Reference model: tracks the age of the accepted transaction in cycles.
  int          age;
  logic        m_single;
  logic [1:0]  m_src_b;
  logic [1:0]  exp_sel;
  logic [15:0] exp_a;
  logic [15:0] exp_b;

  task automatic model_step();
    int last;
    last = m_single ? 1 : 2;
    if (age < 0 || age > last) begin
      if (start_i) begin
        m_single = single_i;
        m_src_b  = src_b_i;
        exp_sel  = src_a_i;
        age      = 0;
      end else begin
        age = -1;
      end
    end else begin
      if (age == 0) begin
        exp_a = mux_in[exp_sel];
        if (!m_single) exp_sel = m_src_b;
      end else if (age == 1 && !m_single) begin
        exp_b = mux_in[exp_sel];
      end
      age++;
    end
  endtask

  initial begin
    int done_count;
    int fetch_count;
    int last;
    logic prev_busy;
    n_checks = 0;
    n_fail   = 0;
    set_default_mux();
    reset_ni = 1'b0;
    start_i  = 1'b0;
    single_i = 1'b0;
    src_a_i  = 2'd0;
    src_b_i  = 2'd0;

    vecs[0] = '{single: 1'b0, src_a: 2'd0, src_b: 2'd3, exp_a: 16'h000A, exp_b: 16'hA000};
    vecs[1] = '{single: 1'b1, src_a: 2'd2, src_b: 2'd1, exp_a: 16'h0A00, exp_b: 16'hA000};
    vecs[2] = '{single: 1'b0, src_a: 2'd1, src_b: 2'd2, exp_a: 16'h00A0, exp_b: 16'h0A00};
    vecs[3] = '{single: 1'b0, src_a: 2'd3, src_b: 2'd0, exp_a: 16'hA000, exp_b: 16'h000A};
    vecs[4] = '{single: 1'b1, src_a: 2'd1, src_b: 2'd3, exp_a: 16'h00A0, exp_b: 16'h000A};

    repeat (2) @(negedge clk_i);
    check_output("reset select", 32'(select_o), 32'd0);
    check_output("reset operand_a", 32'(operand_a_o), 32'd0);
    check_output("reset operand_b", 32'(operand_b_o), 32'd0);
    check_output("reset busy", 32'(busy_o), 32'd0);
    check_output("reset done", 32'(done_o), 32'd0);
    reset_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 5; i++) apply_stimulus(vecs[i], i);

    // Same source twice, with the mux input changing after operand A is captured.
    @(negedge clk_i);
    start_i = 1'b1; single_i = 1'b0; src_a_i = 2'd1; src_b_i = 2'd1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    @(posedge clk_i);
    #1 mux_in[1] = 16'h1234;
    @(negedge clk_i);
    check_output("same-src operand_a", 32'(operand_a_o), 32'h00A0);
    @(negedge clk_i);
    check_output("same-src operand_b", 32'(operand_b_o), 32'h1234);
    check_output("same-src done", 32'(done_o), 32'd1);
    @(negedge clk_i);
    set_default_mux();

    // Start held high: one fetch every four cycles, one done per fetch.
    start_i = 1'b1; single_i = 1'b0; src_a_i = 2'd2; src_b_i = 2'd3;
    done_count = 0; fetch_count = 0; prev_busy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (done_o) done_count++;
      if (busy_o && !prev_busy) fetch_count++;
      prev_busy = busy_o;
      if (k % 4 == 3) check_output("b2b idle gap", 32'({busy_o, done_o}), 32'd0);
    end
    start_i = 1'b0;
    check_output("b2b done count", 32'(done_count), 32'd5);
    check_output("b2b fetch count", 32'(fetch_count), 32'd5);
    repeat (4) @(negedge clk_i);

    // Asynchronous reset in the middle of FETCH_B.
    start_i = 1'b1; single_i = 1'b0; src_a_i = 2'd0; src_b_i = 2'd3;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    @(posedge clk_i);
    #2 reset_ni = 1'b0;
    #1;
    check_output("abort select", 32'(select_o), 32'd0);
    check_output("abort operand_a", 32'(operand_a_o), 32'd0);
    check_output("abort operand_b", 32'(operand_b_o), 32'd0);
    check_output("abort busy", 32'(busy_o), 32'd0);
    check_output("abort done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
    check_output("post-abort done", 32'(done_o), 32'd0);
    check_output("post-abort idle", 32'({select_o, busy_o}), 32'd0);

    // Random phase from the known post-reset state.
    age = -1; m_single = 1'b0; m_src_b = 2'd0;
    exp_sel = 2'd0; exp_a = 16'd0; exp_b = 16'd0;
    for (int c = 0; c < 400; c++) begin
      start_i  = ($urandom_range(0, 2) == 0);
      single_i = $urandom_range(0, 1);
      src_a_i  = $urandom_range(0, 3);
      src_b_i  = $urandom_range(0, 3);
      mux_in[$urandom_range(0, 3)] = 16'($urandom);
      @(posedge clk_i);
      model_step();
      @(negedge clk_i);
      last = m_single ? 1 : 2;
      check_output("rand select", 32'(select_o), 32'(exp_sel));
      check_output("rand operand_a", 32'(operand_a_o), 32'(exp_a));
      check_output("rand operand_b", 32'(operand_b_o), 32'(exp_b));
      check_output("rand busy", 32'(busy_o), 32'(age >= 0 && age < last));
      check_output("rand done", 32'(done_o), 32'(age == last));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
